// File: rtl/dm_pkg.sv
// Shared constants and types for the two-master data-RAM arbiter.
package dm_pkg;
  localparam logic [3:0] BYTEEN_READ = 4'b0000;
  localparam int M0 = 0;
  localparam int M1 = 1;

  typedef enum logic [1:0] {SEL_NONE, SEL_M0, SEL_M1} sel_e;
endpackage

// File: rtl/rr_pick2.sv
// Two-way grant picker: round-robin, or m0 priority with an m1 anti-starvation counter.
module rr_pick2
  import dm_pkg::*;
#(
  parameter int PRIO_M0  = 1,
  parameter int MAX_WAIT = 4,
  localparam int WW      = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output sel_e sel
);

  logic          ptr_q, ptr_d;   // 0: m0 wins the next conflict
  logic [WW-1:0] wait_q, wait_d;

  always_comb begin
    sel = SEL_NONE;
    if (req0 && req1) begin
      if (PRIO_M0 != 0) sel = (wait_q == WW'(MAX_WAIT)) ? SEL_M1 : SEL_M0;
      else              sel = ptr_q ? SEL_M1 : SEL_M0;
    end else if (req0) begin
      sel = SEL_M0;
    end else if (req1) begin
      sel = SEL_M1;
    end

    ptr_d = ptr_q;
    if (sel == SEL_M0)      ptr_d = 1'b1;
    else if (sel == SEL_M1) ptr_d = 1'b0;

    // Counts refused m1 cycles; any m1 grant or idle m1 restarts it.
    wait_d = '0;
    if (req1 && sel != SEL_M1)
      wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q  <= 1'b0;
      wait_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares one single-port data RAM between the CPU data port (m0) and a secondary master (m1).
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int DEPTH    = 4096,
  parameter int AW       = 12,
  parameter int PRIO_M0  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [31:0]   m0_addr,
  input  logic [3:0]    m0_byteen,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic [31:0]   m1_addr,
  input  logic [3:0]    m1_byteen,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  logic [1:0]        req, gnt, oor;
  logic [1:0][31:0]  addr, wdata;
  logic [1:0][3:0]   be;
  logic [1:0]        rvalid_q, rvalid_d, err_q, err_d;
  logic [1:0][31:0]  rdata;
  logic              gi;
  sel_e              sel;
  logic              unused_lsbs;

  // Requests are masked in reset so nothing is granted or strobed to the RAM.
  assign req         = {m1_req, m0_req} & {2{reset}};
  assign addr        = {m1_addr, m0_addr};
  assign wdata       = {m1_wdata, m0_wdata};
  assign be          = {m1_byteen, m0_byteen};
  assign unused_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  rr_pick2 #(.PRIO_M0(PRIO_M0), .MAX_WAIT(MAX_WAIT)) u_pick (
    .clk  (clk),
    .reset(reset),
    .req0 (req[M0]),
    .req1 (req[M1]),
    .sel  (sel)
  );

  always_comb begin
    gnt     = '0;
    gnt[M0] = (sel == SEL_M0);
    gnt[M1] = (sel == SEL_M1);
    gi      = (sel == SEL_M1);
    for (int m = 0; m < 2; m++) begin
      oor[m]      = (addr[m][31:2] >= 30'(DEPTH));
      rvalid_d[m] = gnt[m] && (be[m] == BYTEEN_READ);
      err_d[m]    = gnt[m] && oor[m];
    end
    ram_en    = (|gnt) && !oor[gi];
    ram_we    = ram_en ? be[gi] : 4'b0000;
    ram_addr  = (|gnt) ? addr[gi][AW+1:2] : '0;
    ram_wdata = (|gnt) ? wdata[gi] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= '0;
      err_q    <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // rvalid_q doubles as the read-owner record; out-of-range reads return zero.
  always_comb begin
    for (int m = 0; m < 2; m++)
      rdata[m] = (rvalid_q[m] && !err_q[m]) ? ram_rdata : 32'h0;
  end

  assign m0_gnt    = gnt[M0];
  assign m1_gnt    = gnt[M1];
  assign m0_rvalid = rvalid_q[M0];
  assign m1_rvalid = rvalid_q[M1];
  assign m0_err    = err_q[M0];
  assign m1_err    = err_q[M1];
  assign m0_rdata  = rdata[M0];
  assign m1_rdata  = rdata[M1];

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: priority (inst 0) and round-robin (inst 1) instances with RAM models.
module tb_dm_arbiter;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rq [2][2];
  logic [31:0] ad [2][2];
  logic [3:0]  be [2][2];
  logic [31:0] wd [2][2];

  logic        gnt0 [2], gnt1 [2], rv0 [2], rv1 [2], er0 [2], er1 [2], en [2];
  logic [31:0] rd0 [2], rd1 [2], rw [2];
  logic [3:0]  we [2];
  logic [11:0] ra [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] rrd;
    bit   [31:0] mem [4096];

    dm_arbiter #(.DEPTH(4096), .AW(12), .PRIO_M0(g == 0 ? 1 : 0), .MAX_WAIT(MAX_WAIT)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .m0_req   (rq[g][0]),
      .m0_addr  (ad[g][0]),
      .m0_byteen(be[g][0]),
      .m0_wdata (wd[g][0]),
      .m0_gnt   (gnt0[g]),
      .m0_rvalid(rv0[g]),
      .m0_rdata (rd0[g]),
      .m0_err   (er0[g]),
      .m1_req   (rq[g][1]),
      .m1_addr  (ad[g][1]),
      .m1_byteen(be[g][1]),
      .m1_wdata (wd[g][1]),
      .m1_gnt   (gnt1[g]),
      .m1_rvalid(rv1[g]),
      .m1_rdata (rd1[g]),
      .m1_err   (er1[g]),
      .ram_en   (en[g]),
      .ram_we   (we[g]),
      .ram_addr (ra[g]),
      .ram_wdata(rw[g]),
      .ram_rdata(rrd)
    );

    // Synchronous single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
      if (en[g]) begin
        if (we[g] != 4'b0000) begin
          for (int b = 0; b < 4; b++)
            if (we[g][b]) mem[ra[g]][8*b +: 8] <= rw[g][8*b +: 8];
        end else begin
          rrd <= mem[ra[g]];
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: per-instance memory image and arbitration history.
  bit [31:0] ref_mem [2][4096];
  int        ptr [2], refused [2], last_g [2];

  logic [1:0]  s_gnt [2], s_rv [2], s_err [2];
  logic        s_en [2];
  logic [3:0]  s_we [2];
  logic [11:0] s_addr [2];
  logic [31:0] s_rd [2][2];

  function automatic int pick(int k);
    if (rq[k][0] && rq[k][1]) begin
      if (k == 0) return (refused[k] >= MAX_WAIT) ? 1 : 0;
      return ptr[k];
    end
    if (rq[k][0]) return 0;
    if (rq[k][1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ptr[k] = 0; refused[k] = 0; last_g[k] = -1;
    end
  endtask

  // Call just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic do_cycle();
    int          g [2];
    logic [1:0]  xrv [2], xer [2];
    logic [31:0] xrd [2][2];
    #1;
    for (int k = 0; k < 2; k++) begin
      g[k] = pick(k);
      xrv[k] = '0; xer[k] = '0; xrd[k][0] = '0; xrd[k][1] = '0;
      chk($sformatf("gnt k%0d", k), {gnt1[k], gnt0[k]}, {g[k] == 1, g[k] == 0});
      s_gnt[k] = {gnt1[k], gnt0[k]}; s_en[k] = en[k]; s_we[k] = we[k]; s_addr[k] = ra[k];
      if (g[k] >= 0) begin
        int   m = g[k];
        bit   o = (ad[k][m][31:14] != 0);
        int   w = int'(ad[k][m][13:2]);
        chk($sformatf("ram_en k%0d", k), en[k], !o);
        if (!o) begin
          chk($sformatf("ram_addr k%0d", k), ra[k], ad[k][m][13:2]);
          chk($sformatf("ram_we k%0d", k), we[k], be[k][m]);
          if (be[k][m] != 0) chk($sformatf("ram_wdata k%0d", k), rw[k], wd[k][m]);
        end else begin
          chk($sformatf("ram_we oor k%0d", k), we[k], 4'b0000);
        end
        xrv[k][m] = (be[k][m] == 4'b0000);
        xer[k][m] = o;
        xrd[k][m] = o ? 32'h0 : ref_mem[k][w];
        if (!o)
          for (int b = 0; b < 4; b++)
            if (be[k][m][b]) ref_mem[k][w][8*b +: 8] = wd[k][m][8*b +: 8];
        ptr[k] = 1 - m;
      end else begin
        chk($sformatf("ram_en idle k%0d", k), en[k], 1'b0);
      end
      if (rq[k][1] && g[k] != 1) refused[k] = (refused[k] < MAX_WAIT) ? refused[k] + 1 : MAX_WAIT;
      else                       refused[k] = 0;
      last_g[k] = g[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rvalid k%0d", k), {rv1[k], rv0[k]}, xrv[k]);
      chk($sformatf("err k%0d", k), {er1[k], er0[k]}, xer[k]);
      if (xrv[k][0])      chk($sformatf("m0_rdata k%0d", k), rd0[k], xrd[k][0]);
      else if (xrv[k][1]) chk($sformatf("m0_rdata idle k%0d", k), rd0[k], 32'h0);
      if (xrv[k][1])      chk($sformatf("m1_rdata k%0d", k), rd1[k], xrd[k][1]);
      else if (xrv[k][0]) chk($sformatf("m1_rdata idle k%0d", k), rd1[k], 32'h0);
      s_rv[k] = {rv1[k], rv0[k]}; s_err[k] = {er1[k], er0[k]};
      s_rd[k][0] = rd0[k]; s_rd[k][1] = rd1[k];
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s gnt k%0d", tag, k), {gnt1[k], gnt0[k]}, 2'b00);
      chk($sformatf("%s ram_en/we k%0d", tag, k), {en[k], we[k]}, 5'b0);
      chk($sformatf("%s ram_addr k%0d", tag, k), ra[k], 12'h0);
      chk($sformatf("%s ram_wdata k%0d", tag, k), rw[k], 32'h0);
      chk($sformatf("%s rvalid/err k%0d", tag, k), {rv1[k], rv0[k], er1[k], er0[k]}, 4'b0);
      chk($sformatf("%s m0_rdata k%0d", tag, k), rd0[k], 32'h0);
      chk($sformatf("%s m1_rdata k%0d", tag, k), rd1[k], 32'h0);
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < 2; m++) begin
        rq[k][m] = 1'b0; ad[k][m] = 32'h0; be[k][m] = 4'h0; wd[k][m] = 32'h0;
      end
  endtask

  task automatic new_req(input int k, input int m);
    int word;
    rq[k][m] = ($urandom_range(0, 99) < 65);
    word = ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 15);
    if ($urandom_range(0, 11) == 0) ad[k][m] = 32'h4000 << $urandom_range(0, 17);
    else                            ad[k][m] = {18'h0, 12'(word), 2'($urandom_range(0, 3))};
    be[k][m] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15));
    wd[k][m] = $urandom;
  endtask

  typedef struct {
    logic r0; logic [31:0] a0; logic [3:0] b0; logic [31:0] w0;
    logic r1; logic [31:0] a1; logic [3:0] b1; logic [31:0] w1;
    logic [1:0] e_gnt; logic e_en; logic [3:0] e_we; logic [11:0] e_addr;
    logic [1:0] e_rv; logic [1:0] e_err; logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(logic r0, logic [31:0] a0, logic [3:0] b0, logic [31:0] w0,
                              logic r1, logic [31:0] a1, logic [3:0] b1, logic [31:0] w1,
                              logic [1:0] eg, logic een, logic [3:0] ewe, logic [11:0] ea,
                              logic [1:0] erv, logic [1:0] eer, logic [31:0] erd);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.b0 = b0; v.w0 = w0;
    v.r1 = r1; v.a1 = a1; v.b1 = b1; v.w1 = w1;
    v.e_gnt = eg; v.e_en = een; v.e_we = ewe; v.e_addr = ea;
    v.e_rv = erv; v.e_err = eer; v.e_rd = erd;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    tbl[0]  = mk(1, 32'h10,   4'hF, 32'hDEADBEEF, 0, 32'h0,    4'h0, 32'h0,
                 2'b01, 1, 4'hF, 12'h004, 2'b00, 2'b00, 32'h0);
    tbl[1]  = mk(1, 32'h10,   4'h0, 32'h0,        0, 32'h0,    4'h0, 32'h0,
                 2'b01, 1, 4'h0, 12'h004, 2'b01, 2'b00, 32'hDEADBEEF);
    tbl[2]  = mk(0, 32'h0,    4'h0, 32'h0,        1, 32'h10,   4'b0100, 32'h00AA0000,
                 2'b10, 1, 4'h4, 12'h004, 2'b00, 2'b00, 32'h0);
    tbl[3]  = mk(0, 32'h0,    4'h0, 32'h0,        1, 32'h13,   4'h0, 32'h0,
                 2'b10, 1, 4'h0, 12'h004, 2'b10, 2'b00, 32'hDEAABEEF);
    tbl[4]  = mk(1, 32'h4000, 4'h0, 32'h0,        0, 32'h0,    4'h0, 32'h0,
                 2'b01, 0, 4'h0, 12'h000, 2'b01, 2'b01, 32'h0);
    tbl[5]  = mk(0, 32'h0,    4'h0, 32'h0,        1, 32'h80000000, 4'hF, 32'h11111111,
                 2'b10, 0, 4'h0, 12'h000, 2'b00, 2'b10, 32'h0);
    tbl[6]  = mk(1, 32'h10,   4'h0, 32'h0,        1, 32'h14,   4'h0, 32'h0,
                 2'b01, 1, 4'h0, 12'h004, 2'b01, 2'b00, 32'hDEAABEEF);
    tbl[7]  = mk(0, 32'h0,    4'h0, 32'h0,        1, 32'h14,   4'h0, 32'h0,
                 2'b10, 1, 4'h0, 12'h005, 2'b10, 2'b00, 32'h0);
    tbl[8]  = mk(0, 32'h0,    4'h0, 32'h0,        1, 32'h3FFC, 4'h0, 32'h0,
                 2'b10, 1, 4'h0, 12'hFFF, 2'b10, 2'b00, 32'h0);
    tbl[9]  = mk(1, 32'h3FFC, 4'b0011, 32'h12345678, 0, 32'h0, 4'h0, 32'h0,
                 2'b01, 1, 4'h3, 12'hFFF, 2'b00, 2'b00, 32'h0);
    tbl[10] = mk(1, 32'h3FFC, 4'h0, 32'h0,        0, 32'h0,    4'h0, 32'h0,
                 2'b01, 1, 4'h0, 12'hFFF, 2'b01, 2'b00, 32'h00005678);

    // Reset state with requests pending: nothing may be granted or strobed.
    reset = 1'b0;
    idle_all();
    for (int k = 0; k < 2; k++) begin
      rq[k][0] = 1'b1; rq[k][1] = 1'b1; ad[k][0] = 32'h10; wd[k][1] = 32'hFFFFFFFF; be[k][1] = 4'hF;
    end
    @(negedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    check_all_zero("reset edge");
    @(negedge clk);
    idle_all();
    reset = 1'b1;
    model_reset();

    // Directed vectors on the priority instance.
    for (int i = 0; i < 11; i++) begin
      idle_all();
      rq[0][0] = tbl[i].r0; ad[0][0] = tbl[i].a0; be[0][0] = tbl[i].b0; wd[0][0] = tbl[i].w0;
      rq[0][1] = tbl[i].r1; ad[0][1] = tbl[i].a1; be[0][1] = tbl[i].b1; wd[0][1] = tbl[i].w1;
      do_cycle();
      chk($sformatf("vec%0d gnt", i), s_gnt[0], tbl[i].e_gnt);
      chk($sformatf("vec%0d ram_en", i), s_en[0], tbl[i].e_en);
      if (tbl[i].e_en) begin
        chk($sformatf("vec%0d ram_we", i), s_we[0], tbl[i].e_we);
        chk($sformatf("vec%0d ram_addr", i), s_addr[0], tbl[i].e_addr);
      end
      chk($sformatf("vec%0d rvalid", i), s_rv[0], tbl[i].e_rv);
      chk($sformatf("vec%0d err", i), s_err[0], tbl[i].e_err);
      if (tbl[i].e_rv[0]) chk($sformatf("vec%0d m0_rdata", i), s_rd[0][0], tbl[i].e_rd);
      if (tbl[i].e_rv[1]) chk($sformatf("vec%0d m1_rdata", i), s_rd[0][1], tbl[i].e_rd);
    end

    // Reset lands between a read grant and its data edge: the read is dropped.
    idle_all();
    rq[0][0] = 1'b1; ad[0][0] = 32'h10;
    #1;
    chk("midreset gnt", gnt0[0], 1'b1);
    #1 reset = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    check_all_zero("midreset edge");
    @(negedge clk);
    idle_all();
    reset = 1'b1;
    model_reset();
    do_cycle();
    chk("midreset no late rvalid", {rv1[0], rv0[0]}, 2'b00);

    // Continuous contention: 4:1 pattern for priority, alternation for round-robin.
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 2; k++) begin
        rq[k][0] = 1'b1; ad[k][0] = 32'h10; be[k][0] = 4'h0;
        rq[k][1] = 1'b1; ad[k][1] = 32'h3FFC; be[k][1] = 4'h0;
      end
      do_cycle();
      chk($sformatf("prio seq c%0d", c), 32'(last_g[0]), (c % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("rr seq c%0d", c), 32'(last_g[1]), 32'(c % 2));
    end

    // Random traffic obeying the hold-until-grant rule.
    idle_all();
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++)
        for (int m = 0; m < 2; m++) begin
          if (rq[k][m] && last_g[k] != m) begin
            if ($urandom_range(0, 19) == 0) rq[k][m] = 1'b0;
          end else begin
            new_req(k, m);
          end
        end
      do_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares one synchronous single-port data RAM between two masters:
  - m0: the CPU M-stage data port.
  - m1: a secondary master (loader/DMA/debug).
- Per-cycle arbitration; same-cycle grant; byte-lane writes; one-cycle read latency; address range checking.
- Sits between the CPU data interface and the data RAM in the top-level SoC wrapper.

Parameters:
- DEPTH, 4096, RAM depth in 32-bit words (power of two).
- AW, 12, RAM word-address width, equal to log2(DEPTH).
- PRIO_M0, 1, 1 gives m0 fixed priority with m1 anti-starvation; 0 gives pure round-robin.
- MAX_WAIT, 4, consecutive cycles m1 may be refused before it is forced a grant (PRIO_M0=1 only).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- m0_req  input  1  m0 access request.
- m0_addr  input  32  byte address; bits [1:0] ignored.
- m0_byteen  input  4  write lane enables; 4'b0000 = read.
- m0_wdata  input  32  write data, lane-aligned.
- m0_gnt  output  1  request accepted this cycle (combinational).
- m0_rvalid  output  1  read data valid, one cycle after a granted read.
- m0_rdata  output  32  read data.
- m0_err  output  1  pulse one cycle after a granted out-of-range access.
- m1_req, m1_addr, m1_byteen, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: identical to the m0 set.
- ram_en  output  1  RAM access strobe.
- ram_we  output  4  RAM byte write enables.
- ram_addr  output  AW  RAM word address.
- ram_wdata  output  32  RAM write data.
- ram_rdata  input  32  RAM read data, valid the cycle after ram_en with ram_we=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - All gnt, rvalid and err outputs are 0; rdata is 0; ram_en and ram_we are 0.
  - Round-robin pointer points to m0; wait counter is 0; read-owner register is cleared.
- Per cycle, at most one master is granted. Grant is combinational from req, the pointer and the wait counter.
- Round-robin (PRIO_M0=0):
  - If both request, the master the pointer designates wins.
  - The pointer moves to the other master after every grant.
  - A single requester always wins.
- Fixed priority (PRIO_M0=1):
  - m0 wins a conflict unless wait_cnt == MAX_WAIT, in which case m1 wins.
  - wait_cnt increments (saturating at MAX_WAIT) on each cycle m1_req=1 and m1 is not granted.
  - wait_cnt clears when m1 is granted or when m1_req=0.
- The granted master's request drives the RAM in the same cycle:
  - ram_en=1; ram_addr=addr[AW+1:2]; ram_we=byteen; ram_wdata=wdata.
- Out-of-range access (addr[31:AW+2] != 0):
  - The access is granted but not issued to the RAM (ram_en=0).
  - The requester sees err=1 on the next cycle.
  - For a read, rvalid=1 and rdata=0 on that same next cycle.
- A write completes at grant. There is no rvalid for writes.
- A granted read produces rvalid=1 exactly one cycle later:
  - rdata equals ram_rdata, routed by the registered read owner.
  - The other master's rdata is held at 0.
- Back-to-back reads from alternating masters: each master receives its own data in order. There are no bubbles.
- A non-granted master must hold req, addr, byteen and wdata stable until gnt. Dropping req before gnt is legal and has no side effects.
- Read-after-write to the same word in consecutive cycles returns the new data (RAM is write-first or sequential).
- Reset asserted mid-read: the pending rvalid is discarded and not delivered after reset releases.

Decomposition:
- Shared package dm_pkg holds:
  - The BYTEEN_READ constant (4'b0000).
  - Master index constants M0=0 and M1=1.
  - The grant-select enum {SEL_NONE, SEL_M0, SEL_M1}.
- Sub-module rr_pick2: the 2-way round-robin/priority picker with the wait counter, instantiated once.
- Datapath muxing and rvalid/err pipelining stay in dm_arbiter.

Test Plan:
- m0 only:
  - m0 writes addr 0x10, byteen 4'b1111, data 0xDEADBEEF -> m0_gnt=1, ram_we=4'hF, ram_addr=4.
  - m0 then reads 0x10 -> next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF.
- Byte lanes: m1 writes 0x10 with byteen 4'b0100, data 0x00AA0000 -> subsequent read returns 0xDEAABEEF.
- PRIO_M0=1, MAX_WAIT=4, both masters requesting reads continuously -> m0 granted 4 cycles, m1 granted on the 5th, then the pattern repeats; rvalid data routed to the correct master each time.
- PRIO_M0=0, both requesting every cycle -> grants alternate m0, m1, m0, ..., starting with m0 after reset.
- m0 reads addr 0x4000 (out of range) -> ram_en=0; next cycle m0_err=1, m0_rvalid=1, m0_rdata=0.
- m0 read granted, then reset driven to 0 before the next edge -> m0_rvalid stays 0; all outputs are 0 while reset=0.
